conv_result_collector: RTL and testbench
========================================

// Module: conv_result_collector
// PURPOSE
//  Downstream stage of the convolution core. Captures every partial-sum write (write strobe + index i + temp_z)
//  and coalesces repeated writes to the same index, keeping the last value. Queues the final z[i] values in a FIFO
//  and streams them out over a valid/ready interface. Tags the last sample of each frame.
// PARAMETERS
//  DATA_W   32  width of z samples
//  IDX_W    8   width of output index i
//  DEPTH    16  FIFO entries (power of 2, >=2)
// PORTS
//  clk         in   1       clock
//  rstn        in   1       async active-low reset
//  start_i     in   1       frame start pulse (same pulse that starts the convolution core)
//  wr_i        in   1       partial-result write strobe from convolution core
//  idx_i       in   IDX_W   output index i of the write
//  data_i      in   DATA_W  current accumulated z value
//  done_i      in   1       core done pulse (end of frame)
//  m_valid_o   out  1       output sample valid
//  m_ready_i   in   1       sink ready
//  m_data_o    out  DATA_W  z[i]
//  m_idx_o     out  IDX_W   i
//  m_last_o    out  1       final sample of frame
//  count_o     out  IDX_W+1 samples pushed into FIFO this frame
//  overflow_o  out  1       sticky: a push was dropped (FIFO full)
//  busy_o      out  1       state != IDLE
// BEHAVIOUR
//  Reset: all outputs 0, FIFO empty, hold register invalid, state IDLE.
//  FSM: IDLE -start_i-> COLLECT -done_i-> FLUSH -> DRAIN -(FIFO empty & last beat accepted)-> IDLE.
//   IDLE: wr_i/done_i ignored. start_i clears count_o, overflow_o, hold_valid.
//   start_i outside IDLE is ignored.
//  Hold register {hold_valid, hold_idx, hold_data}, COLLECT only:
//   wr_i & !hold_valid            -> load hold; no push.
//   wr_i & idx_i==hold_idx        -> overwrite hold_data; no push.
//   wr_i & idx_i!=hold_idx        -> push {hold, last=0}; load new value into hold, same cycle.
//   done_i with wr_i, same cycle  -> apply the wr_i rule first, then go to FLUSH.
//  FLUSH (1 cycle): if hold_valid, push {hold, last=1} and clear hold_valid.
//   If hold is empty (no writes in frame): push nothing, m_last_o never asserts, go directly to IDLE.
//  DRAIN: accepts no new writes; returns to IDLE on the handshake of the last=1 entry.
//  Push when FIFO full: entry dropped, overflow_o set, count_o not incremented.
//   A dropped last entry returns the FSM to IDLE directly from FLUSH.
//  Pop and push in the same cycle while full: allowed, no overflow.
//  Output: show-ahead FIFO; m_valid_o rises the cycle after the first push (1-cycle latency).
//   m_data_o/m_idx_o/m_last_o are held stable while m_valid_o & !m_ready_i.
//   Transfer occurs on m_valid_o & m_ready_i.
//  count_o saturates at 2^(IDX_W+1)-1.
//  Pointers: log2(DEPTH)+1 bits, wrap naturally. full = MSBs differ & rest equal.
//  Async reset mid-frame: FIFO flushed, hold discarded, all outputs to reset values immediately.
// STRUCTURE
//  conv_pkg: typedef enum logic [1:0] {CC_IDLE, CC_COLLECT, CC_FLUSH, CC_DRAIN} collector_state_t;
//   default DATA_W/IDX_W localparams shared with the convolution core.
//  Sub-module conv_sync_fifo (WIDTH=DATA_W+IDX_W+1, DEPTH): show-ahead, full/empty, push/pop.
//  Top level holds the FSM, hold register, counter and overflow flag.
// TESTING
//  1 start; wr (i=0,5),(i=0,7),(i=1,3); done; m_ready_i=1
//    -> beats (0,7,last=0), (1,3,last=1); count_o=2; busy_o low after the last beat.
//  2 m_ready_i=0 during a 4-sample frame (DEPTH=16)
//    -> m_valid_o high with data held stable; releasing ready drains in order 0..3 with last on index 3.
//  3 DEPTH=4, ready=0, 6 distinct indices
//    -> 4 entries stored, overflow_o=1, count_o=4; the dropped last entry leaves no m_last_o; FSM returns to IDLE.
//  4 done_i together with wr_i (i=2,9) while hold has i=1
//    -> beats (1,x,last=0), (2,9,last=1).
//  5 start followed by done with no writes
//    -> no m_valid_o; busy_o low 2 cycles after done_i.
//  6 rstn low mid-DRAIN with 3 entries queued
//    -> m_valid_o=0 and busy_o=0 immediately; the next frame starts clean.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution core and its result collector.
// Default widths here must match the convolution core that feeds the collector.
package conv_pkg;

    localparam int unsigned CONV_DATA_W     = 32;
    localparam int unsigned CONV_IDX_W      = 8;
    localparam int unsigned CONV_FIFO_DEPTH = 16;

    typedef enum logic [1:0] {
        CC_IDLE,
        CC_COLLECT,
        CC_FLUSH,
        CC_DRAIN
    } collector_state_t;

endpackage

// File: rtl/conv_sync_fifo.sv
// Show-ahead synchronous FIFO. The head entry is visible on rdata_o whenever empty_o is low.
// A push into a full FIFO is accepted only if a pop happens in the same cycle.
module conv_sync_fifo #(
    parameter int unsigned WIDTH = 41,
    parameter int unsigned DEPTH = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             empty_o,
    output logic             full_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, rptr_q;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Gate the head so the outputs read as zero while nothing is queued.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + (AW+1)'(1);
            if (do_pop)  rptr_q <= rptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/conv_result_collector.sv
// Coalesces repeated partial-sum writes to the same index, queues final z[i] values and streams
// them out over valid/ready, tagging the final sample of each frame.
module conv_result_collector
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = CONV_DATA_W,
    parameter int unsigned IDX_W  = CONV_IDX_W,
    parameter int unsigned DEPTH  = CONV_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start_i,
    input  logic              wr_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              done_i,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic [IDX_W-1:0]  m_idx_o,
    output logic              m_last_o,
    output logic [IDX_W:0]    count_o,
    output logic              overflow_o,
    output logic              busy_o
);

    localparam int unsigned EntW = DATA_W + IDX_W + 1;
    localparam logic [IDX_W:0] CountMax = '1;

    collector_state_t  state_q;
    logic              hold_valid_q;
    logic [IDX_W-1:0]  hold_idx_q;
    logic [DATA_W-1:0] hold_data_q;
    logic [IDX_W:0]    count_q;
    logic              overflow_q;

    logic              push_req, push_ok, fifo_pop;
    logic              fifo_empty, fifo_full;
    logic [EntW-1:0]   push_entry, head;

    // Entry layout: {last, idx, data}
    always_comb begin
        push_req   = 1'b0;
        push_entry = '0;
        case (state_q)
            CC_COLLECT: begin
                if (wr_i && hold_valid_q && (idx_i != hold_idx_q)) begin
                    push_req   = 1'b1;
                    push_entry = {1'b0, hold_idx_q, hold_data_q};
                end
            end
            CC_FLUSH: begin
                if (hold_valid_q) begin
                    push_req   = 1'b1;
                    push_entry = {1'b1, hold_idx_q, hold_data_q};
                end
            end
            default: ;
        endcase
    end

    assign fifo_pop = m_ready_i && !fifo_empty;
    assign push_ok  = !fifo_full || fifo_pop;

    conv_sync_fifo #(
        .WIDTH(EntW),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push_req),
        .wdata_i (push_entry),
        .pop_i   (m_ready_i),
        .rdata_o (head),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= CC_IDLE;
            hold_valid_q <= 1'b0;
            hold_idx_q   <= '0;
            hold_data_q  <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
        end else begin
            if (push_req) begin
                if (!push_ok) begin
                    overflow_q <= 1'b1;
                end else if (count_q != CountMax) begin
                    count_q <= count_q + (IDX_W+1)'(1);
                end
            end
            case (state_q)
                CC_IDLE: begin
                    if (start_i) begin
                        state_q      <= CC_COLLECT;
                        count_q      <= '0;
                        overflow_q   <= 1'b0;
                        hold_valid_q <= 1'b0;
                    end
                end
                CC_COLLECT: begin
                    // Every write lands in the hold register; an index change pushed the old one.
                    if (wr_i) begin
                        hold_valid_q <= 1'b1;
                        hold_idx_q   <= idx_i;
                        hold_data_q  <= data_i;
                    end
                    if (done_i) state_q <= CC_FLUSH;
                end
                CC_FLUSH: begin
                    hold_valid_q <= 1'b0;
                    // No last entry queued means nothing will ever end the drain.
                    state_q <= (hold_valid_q && push_ok) ? CC_DRAIN : CC_IDLE;
                end
                CC_DRAIN: begin
                    if (m_valid_o && m_ready_i && m_last_o) state_q <= CC_IDLE;
                end
                default: state_q <= CC_IDLE;
            endcase
        end
    end

    assign m_valid_o  = !fifo_empty;
    assign m_last_o   = head[EntW-1];
    assign m_idx_o    = head[DATA_W +: IDX_W];
    assign m_data_o   = head[DATA_W-1:0];
    assign count_o    = count_q;
    assign overflow_o = overflow_q;
    assign busy_o     = (state_q != CC_IDLE);

endmodule

// File: tb/tb_conv_result_collector.sv
// Scoreboard bench for conv_result_collector: a frame-level model predicts the output beats,
// a negedge monitor compares every handshake; a DEPTH=4 instance covers the overflow case.
module tb_conv_result_collector;

    typedef struct packed {
        logic        last;
        logic [7:0]  idx;
        logic [31:0] data;
    } exp_t;

    logic        clk, rstn;
    logic        start_i, wr_i, done_i, m_ready_i;
    logic [7:0]  idx_i;
    logic [31:0] data_i;
    logic        m_valid_o, m_last_o, overflow_o, busy_o;
    logic [31:0] m_data_o;
    logic [7:0]  m_idx_o;
    logic [8:0]  count_o;

    logic        en4, r4, v4, last4, ovf4, busy4;
    logic [31:0] data4;
    logic [7:0]  idx4;
    logic [8:0]  count4;

    int          checks = 0;
    int          failures = 0;
    int          ready_mode = 1;
    exp_t        sb[$];
    exp_t        runs_q[$];
    logic [7:0]  wq_idx[$];
    logic [31:0] wq_data[$];

    conv_result_collector #(.DATA_W(32), .IDX_W(8), .DEPTH(16)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .wr_i(wr_i), .idx_i(idx_i),
        .data_i(data_i), .done_i(done_i), .m_valid_o(m_valid_o), .m_ready_i(m_ready_i),
        .m_data_o(m_data_o), .m_idx_o(m_idx_o), .m_last_o(m_last_o), .count_o(count_o),
        .overflow_o(overflow_o), .busy_o(busy_o)
    );

    conv_result_collector #(.DATA_W(32), .IDX_W(8), .DEPTH(4)) dut4 (
        .clk(clk), .rstn(rstn), .start_i(start_i && en4), .wr_i(wr_i), .idx_i(idx_i),
        .data_i(data_i), .done_i(done_i), .m_valid_o(v4), .m_ready_i(r4),
        .m_data_o(data4), .m_idx_o(idx4), .m_last_o(last4), .count_o(count4),
        .overflow_o(ovf4), .busy_o(busy4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sink ready pattern: 0 = stalled, 1 = always ready, otherwise random.
    initial begin
        m_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       m_ready_i = 1'b0;
                1:       m_ready_i = 1'b1;
                default: m_ready_i = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    // Monitor: checks hold-while-stalled and pops the scoreboard on each handshake.
    initial begin
        exp_t        e;
        logic        stall = 1'b0;
        logic [40:0] held = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                stall = 1'b0;
                continue;
            end
            if (stall) begin
                chk("stall_valid", m_valid_o, 1'b1);
                chk("stall_stable", {m_last_o, m_idx_o, m_data_o}, held);
            end
            if (m_valid_o && m_ready_i) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", {m_last_o, m_idx_o, m_data_o}, 41'h0);
                end else begin
                    e = sb.pop_front();
                    chk("beat_idx", m_idx_o, e.idx);
                    chk("beat_data", m_data_o, e.data);
                    chk("beat_last", m_last_o, e.last);
                end
            end
            stall = m_valid_o && !m_ready_i;
            held  = {m_last_o, m_idx_o, m_data_o};
        end
    end

    // Model: each run of consecutive equal indices yields one beat with the run's final value;
    // the frame's final beat carries last.
    task automatic send_frame(input bit done_with_wr, output int runs);
        exp_t e;
        int   n = wq_idx.size();
        runs_q.delete();
        for (int k = 0; k < n; k++) begin
            if (k == n - 1 || wq_idx[k+1] != wq_idx[k]) begin
                e.idx  = wq_idx[k];
                e.data = wq_data[k];
                e.last = (k == n - 1);
                runs_q.push_back(e);
                sb.push_back(e);
            end
        end
        runs = runs_q.size();
        // Writes in IDLE must be ignored.
        wr_i = 1'b1; idx_i = 8'($urandom); data_i = $urandom;
        step();
        wr_i = 1'b0;
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) step();
            wr_i = 1'b1; idx_i = wq_idx[k]; data_i = wq_data[k];
            if (k == n - 1 && done_with_wr) done_i = 1'b1;
            step();
            wr_i = 1'b0; done_i = 1'b0;
        end
        if (!(done_with_wr && n > 0)) begin
            done_i = 1'b1;
            step();
            done_i = 1'b0;
        end
        // Write during FLUSH/IDLE must be ignored.
        wr_i = 1'b1; idx_i = 8'($urandom); data_i = $urandom;
        step();
        wr_i = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int runs);
        int c = 0;
        while ((busy_o || m_valid_o) && c < 3000) begin
            step();
            c++;
        end
        chk({name, "_idle_in_time"}, (c < 3000), 1'b1);
        chk({name, "_sb_empty"}, sb.size(), 0);
        chk({name, "_count"}, count_o, runs);
        chk({name, "_overflow"}, overflow_o, 1'b0);
    endtask

    initial begin
        int runs, got, n;
        clk = 0; rstn = 1; start_i = 0; wr_i = 0; done_i = 0; idx_i = 0; data_i = 0;
        en4 = 0; r4 = 0;
        #1 rstn = 0;
        #20;
        chk("rst_valid", m_valid_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_count", count_o, 0);
        chk("rst_overflow", overflow_o, 1'b0);
        chk("rst_out", {m_last_o, m_idx_o, m_data_o}, 41'h0);
        chk("rst4_valid", v4, 1'b0);
        @(posedge clk); #3 rstn = 1;
        step();

        // Coalescing of repeated index, last on final beat.
        ready_mode = 1;
        wq_idx = '{8'd0, 8'd0, 8'd1}; wq_data = '{32'd5, 32'd7, 32'd3};
        send_frame(1'b0, runs);
        finish_frame("t1", runs);
        chk("t1_count_lit", count_o, 2);

        // Stalled sink, data held, then in-order drain; stray start in DRAIN ignored.
        ready_mode = 0;
        wq_idx = '{8'd0, 8'd1, 8'd2, 8'd3};
        wq_data = '{$urandom, $urandom, $urandom, $urandom};
        send_frame(1'b0, runs);
        start_i = 1'b1; step(); start_i = 1'b0;
        repeat (5) step();
        chk("t2_valid_stalled", m_valid_o, 1'b1);
        chk("t2_busy_stalled", busy_o, 1'b1);
        ready_mode = 1;
        finish_frame("t2", runs);

        // done_i together with a write to a new index.
        ready_mode = 2;
        wq_idx = '{8'd1, 8'd2}; wq_data = '{$urandom, 32'd9};
        send_frame(1'b1, runs);
        finish_frame("t4", runs);

        // DEPTH=4 instance, stalled sink, 6 distinct indices.
        ready_mode = 1; en4 = 1; r4 = 0;
        wq_idx = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
        wq_data = '{$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        send_frame(1'b0, runs);
        en4 = 0;
        finish_frame("t3main", runs);
        chk("t3_busy4", busy4, 1'b0);
        chk("t3_count4", count4, (runs < 4) ? runs : 4);
        chk("t3_ovf4", ovf4, (runs > 4));
        chk("t3_valid4", v4, 1'b1);
        r4 = 1; got = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (v4 && r4) begin
                if (got < runs_q.size()) begin
                    chk("t3_beat_idx", idx4, runs_q[got].idx);
                    chk("t3_beat_data", data4, runs_q[got].data);
                end
                chk("t3_beat_last", last4, 1'b0);
                got++;
            end
        end
        #1;
        chk("t3_beats4", got, 4);
        chk("t3_valid4_end", v4, 1'b0);
        r4 = 0;

        // Empty frame: nothing queued, busy drops two cycles after done.
        start_i = 1'b1; step(); start_i = 1'b0;
        done_i = 1'b1; step(); done_i = 1'b0;
        chk("t5_busy_flush", busy_o, 1'b1);
        step();
        chk("t5_busy_idle", busy_o, 1'b0);
        repeat (3) step();
        chk("t5_no_valid", m_valid_o, 1'b0);
        chk("t5_count", count_o, 0);

        // Randomized frames.
        for (int f = 0; f < 25; f++) begin
            ready_mode = 2;
            n = $urandom_range(0, 14);
            wq_idx.delete(); wq_data.delete();
            for (int k = 0; k < n; k++) begin
                wq_idx.push_back(8'($urandom_range(0, 3)));
                wq_data.push_back($urandom);
            end
            send_frame(bit'($urandom_range(0, 1)), runs);
            finish_frame("rand", runs);
        end

        // Asynchronous reset in DRAIN with three entries queued.
        ready_mode = 0;
        wq_idx = '{8'd7, 8'd8, 8'd9};
        wq_data = '{$urandom, $urandom, $urandom};
        send_frame(1'b0, runs);
        step();
        chk("t6_busy_pre", busy_o, 1'b1);
        chk("t6_valid_pre", m_valid_o, 1'b1);
        #2 rstn = 0;
        #1;
        chk("t6_valid_rst", m_valid_o, 1'b0);
        chk("t6_busy_rst", busy_o, 1'b0);
        chk("t6_count_rst", count_o, 0);
        sb.delete();
        @(posedge clk); #3 rstn = 1;
        step();
        ready_mode = 2;
        wq_idx = '{8'd3, 8'd3, 8'd4};
        wq_data = '{$urandom, $urandom, $urandom};
        send_frame(1'b0, runs);
        finish_frame("t6_post", runs);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
